// File: rtl/alu_sequencer.sv
// alu_sequencer: steps a 32-entry instruction memory into an ALU with ready/valid handshake and repeat passes.
// Optional ALU_SEQ_ABORT_EN adds an abort_i input that returns RUN to IDLE without a done pulse.
module alu_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef ALU_SEQ_ABORT_EN
  input  logic        abort_i,
`endif
  input  logic        start_i,
  input  logic [7:0]  repeat_i,
  input  logic        prog_we_i,
  input  logic [4:0]  prog_addr_i,
  input  logic [20:0] prog_data_i,
  input  logic        alu_ready_i,
  output logic [3:0]  opcode_o,
  output logic [15:0] operand_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [7:0]  pass_q, pass_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [15:0] operand_q, operand_d;
  logic        valid_q, valid_d, done_q, done_d;
  logic        ld, abort, last;
  logic [20:0] mem [32];
`ifdef ALU_SEQ_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif
  // address 31 terminates the pass so pc never wraps
  assign last = mem[pc_q][20] || (pc_q == 5'd31);
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pass_d    = pass_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    ld        = 1'b0;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        pc_d    = 5'd0;
        pass_d  = repeat_i;
        valid_d = 1'b1;
        ld      = 1'b1;
      end
      RUN: if (abort) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end else if (alu_ready_i) begin
        if (!last) begin
          pc_d = pc_q + 5'd1;
          ld   = 1'b1;
        end else if (pass_q != 8'd0) begin
          pass_d = pass_q - 8'd1;
          pc_d   = 5'd0;
          ld     = 1'b1;
        end else begin
          state_d = DONE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ld) {opcode_d, operand_d} = mem[pc_d][19:0];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      pass_q    <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pass_q    <= pass_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end
  // program memory has no reset and is frozen while running
  always_ff @(posedge clk_i) begin
    if (prog_we_i && state_q != RUN) mem[prog_addr_i] <= prog_data_i;
  end
  assign opcode_o  = opcode_q;
  assign operand_o = operand_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q == RUN);
  assign done_o    = done_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector table plus randomized runs checked against a program-level reference model.
module tb_alu_sequencer;
  logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, prog_we_i = 1'b0, alu_ready_i = 1'b0;
  logic [7:0]  repeat_i = '0;
  logic [4:0]  prog_addr_i = '0;
  logic [20:0] prog_data_i = '0;
  logic [3:0]  opcode_o;
  logic [15:0] operand_o;
  logic        valid_o, busy_o, done_o;
`ifdef ALU_SEQ_ABORT_EN
  logic        abort_i = 1'b0;
`endif
  int checks = 0, failures = 0;
  logic [20:0] prog [32];

  alu_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
`ifdef ALU_SEQ_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i), .repeat_i(repeat_i), .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i),
    .prog_data_i(prog_data_i), .alu_ready_i(alu_ready_i), .opcode_o(opcode_o), .operand_o(operand_o),
    .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start, ready;
    logic        valid, busy, done;
    logic [3:0]  op;
    logic [15:0] opnd;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [20:0] d);
    prog_we_i = 1'b1; prog_addr_i = a; prog_data_i = d;
    @(negedge clk_i);
    prog_we_i = 1'b0;
    prog[a] = d;
  endtask

  task automatic chk_zero(input string n);
    chk({n, ".opcode"}, 32'(opcode_o), 0);
    chk({n, ".operand"}, 32'(operand_o), 0);
    chk({n, ".valid"}, 32'(valid_o), 0);
    chk({n, ".busy"}, 32'(busy_o), 0);
    chk({n, ".done"}, 32'(done_o), 0);
  endtask

  task automatic apply_table(input string n);
    for (int i = 0; i < 4; i++) begin
      start_i = tbl[i].start; alu_ready_i = tbl[i].ready; repeat_i = 8'd0;
      @(negedge clk_i);
      start_i = 1'b0;
      chk($sformatf("%s%0d.valid", n, i), 32'(valid_o), 32'(tbl[i].valid));
      chk($sformatf("%s%0d.busy", n, i), 32'(busy_o), 32'(tbl[i].busy));
      chk($sformatf("%s%0d.done", n, i), 32'(done_o), 32'(tbl[i].done));
      chk($sformatf("%s%0d.opcode", n, i), 32'(opcode_o), 32'(tbl[i].op));
      chk($sformatf("%s%0d.operand", n, i), 32'(operand_o), 32'(tbl[i].opnd));
    end
  endtask

  // expected accepts are the program prefix up to the first end flag (or addr 31), repeated rep+1 times
  task automatic run_model(input int rep);
    logic [19:0] exp [$];
    logic [19:0] held;
    logic        held_valid;
    int          len, cyc;
    len = 32;
    for (int i = 0; i < 32; i++) if (prog[i][20]) begin len = i + 1; break; end
    for (int p = 0; p <= rep; p++) for (int i = 0; i < len; i++) exp.push_back(prog[i][19:0]);
    start_i = 1'b1; repeat_i = 8'(rep); alu_ready_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    start_i = 1'b0; held_valid = 1'b0; held = '0; cyc = 0;
    while (!done_o && cyc < 3000) begin
      chk("busy_vs_valid", 32'(busy_o), 32'(valid_o));
      if (held_valid) chk("hold", 32'({opcode_o, operand_o}), 32'(held));
      alu_ready_i = ($urandom_range(0, 3) != 0);
      prog_we_i = busy_o && ($urandom_range(0, 1) == 1);
      prog_addr_i = 5'($urandom); prog_data_i = 21'($urandom);
      held_valid = valid_o && !alu_ready_i;
      held = {opcode_o, operand_o};
      if (valid_o && alu_ready_i) begin
        if (exp.size() == 0) chk("extra_accept", 1, 0);
        else chk("accept", 32'({opcode_o, operand_o}), 32'(exp.pop_front()));
      end
      @(negedge clk_i);
      cyc++;
    end
    prog_we_i = 1'b0;
    chk("run_timeout", 32'(cyc < 3000), 1);
    chk("missing_accepts", 32'(exp.size()), 0);
    chk("run_done", 32'(done_o), 1);
    chk("run_done_valid", 32'(valid_o), 0);
    @(negedge clk_i);
    chk("run_done_once", 32'(done_o), 0);
    chk("run_idle_busy", 32'(busy_o), 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 16'h1234};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h8, 16'h0001};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 16'h0001};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h8, 16'h0001};
    repeat (2) @(negedge clk_i);
    chk_zero("reset");
    rst_i = 1'b0;
    wr(5'd0, {1'b0, 4'h0, 16'h1234});
    wr(5'd1, {1'b1, 4'h8, 16'h0001});
    apply_table("basic");
    // ready held low three cycles on the first instruction
    start_i = 1'b1; alu_ready_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d", k), 32'({valid_o, opcode_o, operand_o}), 32'({1'b1, 4'h0, 16'h1234}));
      if (k < 3) @(negedge clk_i);
    end
    alu_ready_i = 1'b1;
    @(negedge clk_i);
    chk("stall_advance", 32'({opcode_o, operand_o}), 32'({4'h8, 16'h0001}));
    @(negedge clk_i);
    chk("stall_done", 32'(done_o), 1);
    @(negedge clk_i);
    run_model(2);
    // reset while the second instruction is presented
    start_i = 1'b1; alu_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    chk("midrun_second", 32'(opcode_o), 32'h8);
    rst_i = 1'b1; alu_ready_i = 1'b0;
    #1 chk_zero("midrun_rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_zero("after_rst");
    apply_table("restart");
`ifdef ALU_SEQ_ABORT_EN
    start_i = 1'b1; alu_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b1;
    prog_we_i = 1'b1; prog_addr_i = 5'd0; prog_data_i = 21'h1FFFFF;
    @(negedge clk_i);
    abort_i = 1'b0; prog_we_i = 1'b0;
    chk("abort.valid", 32'(valid_o), 0);
    chk("abort.busy", 32'(busy_o), 0);
    chk("abort.done", 32'(done_o), 0);
    @(negedge clk_i);
    chk("abort.done_late", 32'(done_o), 0);
    apply_table("post_abort");
`endif
    for (int i = 0; i < 32; i++) wr(5'(i), {1'b0, 20'($urandom)});
    run_model(0);
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) wr(5'(i), {($urandom_range(0, 5) == 0), 20'($urandom)});
      run_model(int'($urandom_range(0, 2)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
